// File: rtl/bf_program_loader.sv
// bf_program_loader: filters a byte stream down to brainfuck opcodes and writes them plus a 0x00 terminator into program RAM; define BF_LOADER_BRACKET_CHECK_EN to enable bracket balance checking
module bf_program_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   prog_len,
    output logic              bracket_err
);
    typedef enum logic [1:0] {IDLE, LOAD, TERM, DONE} state_t;
    localparam logic [ADDR_W:0] CAP_M1 = (ADDR_W+1)'((1 << ADDR_W) - 2);
    state_t          state;
    logic [ADDR_W:0] count;
    logic            legal;
    logic            full;
    assign legal    = in_data inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
    assign full     = legal && count == CAP_M1;
    assign in_ready = state == LOAD;
    assign busy     = state == LOAD || state == TERM;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            done      <= 1'b0;
            overflow  <= 1'b0;
            prog_len  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state    <= LOAD;
                    count    <= '0;
                    done     <= 1'b0;
                    overflow <= 1'b0;
                    prog_len <= '0;
                end
                LOAD: if (in_valid) begin
                    if (legal) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= count[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        count     <= count + 1'b1;
                    end
                    if (in_last || full) state <= TERM;
                    if (full && !in_last) overflow <= 1'b1;
                end
                TERM: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= count[ADDR_W-1:0];
                    mem_wdata <= 8'h00;
                    prog_len  <= count;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef BF_LOADER_BRACKET_CHECK_EN
    logic signed [ADDR_W:0] depth;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth       <= '0;
            bracket_err <= 1'b0;
        end else if (start && (state == IDLE || state == DONE)) begin
            depth       <= '0;
            bracket_err <= 1'b0;
        end else if (state == LOAD && in_valid && in_data == 8'h5B) begin
            depth <= depth + 1'b1;
        end else if (state == LOAD && in_valid && in_data == 8'h5D) begin
            depth <= depth - 1'b1;
            if (depth == '0) bracket_err <= 1'b1;
        end else if (state == TERM && depth != '0) begin
            bracket_err <= 1'b1;
        end
    end
`else
    assign bracket_err = 1'b0;
`endif
endmodule
